string_fetch_arbiter: RTL and testbench

//  Shares the single Data_Memory port between the CPU load/store path and a

---
 rtl/string_fetch_arbiter_if.sv | 48 ++++
 rtl/string_fetch_arbiter.sv | 138 +++++++++++++
 tb/tb_string_fetch_arbiter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/string_fetch_arbiter_if.sv
// Bus bundle for the string fetch arbiter.
// Carries three groups of signals:
//   - the CPU load/store request: cpu_* and cpu_stall
//   - the shared Data_Memory port: mem_*
//   - the print-string engine control and character stream:
//     start, start_addr, busy, char_*, done, truncated
// The arbiter connects through the slave modport. The CPU, the memory and the
// console side connect through the master modport.
interface string_fetch_arbiter_if;
  logic        cpu_memRead;
  logic        cpu_memWrite;
  logic [31:0] cpu_address;
  logic [31:0] cpu_writeData;
  logic        cpu_stall;

  logic        mem_memRead;
  logic        mem_memWrite;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;

  logic        start;
  logic [31:0] start_addr;
  logic        busy;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        done;
  logic        truncated;

  modport slave (
    input  cpu_memRead, cpu_memWrite, cpu_address, cpu_writeData,
    output cpu_stall,
    output mem_memRead, mem_memWrite, mem_address, mem_writeData,
    input  mem_readData,
    input  start, start_addr, char_ready,
    output busy, char_valid, char_data, done, truncated
  );

  modport master (
    output cpu_memRead, cpu_memWrite, cpu_address, cpu_writeData,
    input  cpu_stall,
    input  mem_memRead, mem_memWrite, mem_address, mem_writeData,
    output mem_readData,
    output start, start_addr, char_ready,
    input  busy, char_valid, char_data, done, truncated
  );
endinterface

// File: rtl/string_fetch_arbiter.sv
// Shares the single Data_Memory port between the CPU load/store path and a
// print-string fetch engine. The engine reads a NUL-terminated string one word
// at a time. It streams the bytes out over a valid/ready handshake.
// The CPU has priority. After STARVE_LIMIT consecutive CPU wins, the engine is
// given the port.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    string_fetch_arbiter_if.slave, carrying the CPU request, the
//          memory port and the engine start/character/done signals
module string_fetch_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_LEN      = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  string_fetch_arbiter_if.slave bus
);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     word_addr;
  logic [1:0]      idx;
  logic [CW-1:0]   byte_cnt;
  logic [SW-1:0]   starve_cnt;
  logic [31:0]     word_buf;
  logic            trunc_r;

  logic            cpu_req;
  logic            cpu_wins;
  logic            eng_grant;
  logic            last_char;
  logic [7:0]      cur_byte;

  // The CPU keeps the port while its win streak is below the limit.
  assign cpu_req   = bus.cpu_memRead | bus.cpu_memWrite;
  assign cpu_wins  = cpu_req && (32'(starve_cnt) < STARVE_LIMIT);
  assign eng_grant = (state == REQ) && !cpu_wins;
  assign cur_byte  = word_buf[{idx, 3'b000} +: 8];
  assign last_char = (32'(byte_cnt) + 32'd1) == MAX_LEN;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = REQ;
      REQ:  if (!cpu_wins) state_nxt = WAIT;
      WAIT: state_nxt = EMIT;
      EMIT: begin
        if (cur_byte == 8'd0)   state_nxt = DONE;
        else if (bus.char_ready) begin
          if (last_char)        state_nxt = DONE;
          else if (idx == 2'd3) state_nxt = REQ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Engine datapath: address/byte cursor, counters, word buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_addr  <= '0;
      idx        <= '0;
      byte_cnt   <= '0;
      starve_cnt <= '0;
      word_buf   <= '0;
      trunc_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          word_addr <= {bus.start_addr[31:2], 2'b00};
          idx       <= bus.start_addr[1:0];
          byte_cnt  <= '0;
          trunc_r   <= 1'b0;
        end
        REQ: begin
          if (cpu_wins) starve_cnt <= starve_cnt + SW'(1);
          else          starve_cnt <= '0;
        end
        WAIT: word_buf <= bus.mem_readData;
        EMIT: begin
          if (cur_byte == 8'd0) trunc_r <= 1'b0;
          else if (bus.char_ready) begin
            byte_cnt <= byte_cnt + CW'(1);
            if (last_char) trunc_r <= 1'b1;
            else if (idx == 2'd3) begin
              idx       <= 2'd0;
              word_addr <= word_addr + 32'd4;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: the memory mux passes the CPU through except in the engine-grant cycle
  always_comb begin
    bus.busy          = (state != IDLE);
    bus.char_valid    = 1'b0;
    bus.char_data     = 8'd0;
    bus.done          = 1'b0;
    bus.truncated     = 1'b0;
    bus.cpu_stall     = 1'b0;
    bus.mem_memRead   = bus.cpu_memRead;
    bus.mem_memWrite  = bus.cpu_memWrite;
    bus.mem_address   = bus.cpu_address;
    bus.mem_writeData = bus.cpu_writeData;
    if (state == EMIT) begin
      bus.char_data  = cur_byte;
      bus.char_valid = (cur_byte != 8'd0);
    end
    if (state == DONE) begin
      bus.done      = 1'b1;
      bus.truncated = trunc_r;
    end
    if (eng_grant) begin
      bus.mem_memRead   = 1'b1;
      bus.mem_memWrite  = 1'b0;
      bus.mem_address   = word_addr;
      bus.mem_writeData = 32'd0;
      bus.cpu_stall     = cpu_req;
    end
  end
endmodule

// File: tb/tb_string_fetch_arbiter.sv
// Self-checking bench for string_fetch_arbiter.
// A word-addressed memory model reads on posedge and writes on negedge.
// A reference model derives, from the memory contents, the expected character
// stream, the truncation flag and the word reads for each start address.
module tb_string_fetch_arbiter;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned MAX_LEN      = 255;

  logic clk = 1'b0;
  logic reset;
  string_fetch_arbiter_if bus();

  string_fetch_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Memory model
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_q;
  assign bus.mem_readData = rd_q;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return mem.exists(w) ? mem[w] : 32'd0;
  endfunction

  function automatic logic [7:0] byte_rd(input logic [31:0] a);
    logic [31:0] w;
    w = mem_rd(a);
    return w[int'(a[1:0]) * 8 +: 8];
  endfunction

  task automatic byte_wr(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = mem_rd(a);
    w[int'(a[1:0]) * 8 +: 8] = b;
    mem[{a[31:2], 2'b00}] = w;
  endtask

  always @(posedge clk) if (bus.mem_memRead) rd_q <= mem_rd(bus.mem_address);
  always @(negedge clk) if (bus.mem_memWrite) mem[{bus.mem_address[31:2], 2'b00}] = bus.mem_writeData;

  // Monitor
  logic [7:0]  got_chars[$];
  logic [31:0] got_reads[$];
  int          stall_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          pass_err = 0;
  int          start_cyc = 0;
  logic        last_trunc = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus.char_valid && bus.char_ready) got_chars.push_back(bus.char_data);
      if (bus.cpu_stall) stall_cyc.push_back(cyc);
      if (bus.mem_memRead && (bus.cpu_stall || !(bus.cpu_memRead || bus.cpu_memWrite)))
        got_reads.push_back(bus.mem_address);
      if ((bus.cpu_memRead || bus.cpu_memWrite) && !bus.cpu_stall &&
          (bus.mem_address !== bus.cpu_address || bus.mem_memRead !== bus.cpu_memRead ||
           bus.mem_memWrite !== bus.cpu_memWrite))
        pass_err++;
      if (bus.done) begin
        done_cnt++;
        last_trunc = bus.truncated;
      end
    end
  end

  // Reference model: walk bytes from the start address until NUL or MAX_LEN
  logic [7:0]  exp_chars[$];
  logic [31:0] exp_reads[$];
  bit          exp_trunc;

  task automatic model_string(input logic [31:0] addr);
    logic [31:0] a, last, w;
    exp_chars.delete();
    exp_reads.delete();
    exp_trunc = 1'b0;
    a = addr;
    last = addr;
    for (int k = 0; k <= int'(MAX_LEN); k++) begin
      if (exp_chars.size() == int'(MAX_LEN)) begin
        exp_trunc = 1'b1;
        last = a - 32'd1;
        break;
      end
      if (byte_rd(a) == 8'd0) begin
        last = a;
        break;
      end
      exp_chars.push_back(byte_rd(a));
      a = a + 32'd1;
    end
    w = {addr[31:2], 2'b00};
    for (int k = 0; k < 100; k++) begin
      exp_reads.push_back(w);
      if (w == {last[31:2], 2'b00}) break;
      w = w + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    bus.cpu_memRead   = 1'b0;
    bus.cpu_memWrite  = 1'b0;
    bus.cpu_address   = 32'd0;
    bus.cpu_writeData = 32'd0;
  endtask

  // Stimulus driver: cpu_mode 0 idle, 1 random reads, 2 constant reads
  task automatic drive_cpu(input int cpu_mode);
    if (cpu_mode == 2) begin
      bus.cpu_memRead = 1'b1;
      bus.cpu_address = 32'h5000_0000;
    end else if (cpu_mode == 1) begin
      bus.cpu_memRead = ($urandom_range(1) == 1);
      bus.cpu_address = 32'h4000_0000 + 32'($urandom_range(255)) * 32'd4;
    end else begin
      cpu_idle();
    end
  endtask

  task automatic run_string(input logic [31:0] addr, input int ready_pct, input int cpu_mode,
                            input bit spurious, output bit timeout);
    int d0;
    d0 = done_cnt;
    got_chars.delete();
    got_reads.delete();
    stall_cyc.delete();
    drive_cpu(cpu_mode);
    bus.char_ready = 1'b0;
    bus.start      = 1'b1;
    bus.start_addr = addr;
    start_cyc      = cyc + 1;
    tick();
    timeout = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      bus.char_ready = ($urandom_range(99) < ready_pct);
      drive_cpu(cpu_mode);
      if (spurious && i == 3) begin
        bus.start      = 1'b1;
        bus.start_addr = addr + 32'h100;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (done_cnt != d0) begin
        timeout = 1'b0;
        break;
      end
    end
    bus.start      = 1'b0;
    bus.char_ready = 1'b0;
    cpu_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_idle();
    bus.start = 1'b0;
    bus.start_addr = 32'd0;
    bus.char_ready = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.char_valid !== 1'b0 || bus.done !== 1'b0 || bus.truncated !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b valid=%b done=%b trunc=%b, expected all 0",
               bus.busy, bus.char_valid, bus.done, bus.truncated);
    end
    tests_run++;
    if (bus.char_data !== 8'd0 || bus.cpu_stall !== 1'b0 || bus.mem_memRead !== 1'b0 || bus.mem_memWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_bus: data=%h stall=%b rd=%b wr=%b, expected 0", bus.char_data,
               bus.cpu_stall, bus.mem_memRead, bus.mem_memWrite);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b, expected 0", bus.busy);
    end
    tick();
  endtask

  task automatic test_hi();
    logic [31:0] a;
    bit to;
    int d0;
    a = 32'h7FFF_FBF0;
    byte_wr(a, 8'h48); byte_wr(a + 1, 8'h69); byte_wr(a + 2, 8'h00);
    d0 = done_cnt;
    run_string(a, 100, 0, 1'b0, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL hi_timeout: no done pulse within budget"); end
    tests_run++;
    if (got_chars.size() != 2 || got_chars[0] !== 8'h48 || got_chars[1] !== 8'h69) begin
      tests_failed++;
      $display("FAIL hi_chars: got %0d chars (first %h), expected 48 69", got_chars.size(),
               got_chars.size() > 0 ? got_chars[0] : 8'h00);
    end
    tests_run++;
    if (done_cnt - d0 != 1 || last_trunc !== 1'b0) begin
      tests_failed++;
      $display("FAIL hi_done: done pulses=%0d trunc=%b, expected 1 and 0", done_cnt - d0, last_trunc);
    end
    tests_run++;
    if (got_reads.size() != 1 || got_reads[0] !== a) begin
      tests_failed++;
      $display("FAIL hi_reads: got %0d reads, expected exactly 1 at %h", got_reads.size(), a);
    end
  endtask

  task automatic test_unaligned();
    logic [31:0] a;
    bit to;
    a = 32'h7FFF_FBF0;
    mem[a] = 32'h6463_6261;        // "abcd"
    mem[a + 4] = 32'h7800_6665;    // "ef\0x"
    run_string(a + 2, 100, 0, 1'b1, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL unal_timeout: no done pulse within budget"); end
    tests_run++;
    if (got_chars.size() != 4 || got_chars[0] !== 8'h63 || got_chars[1] !== 8'h64 ||
        got_chars[2] !== 8'h65 || got_chars[3] !== 8'h66) begin
      tests_failed++;
      $display("FAIL unal_chars: got %0d chars, expected c d e f", got_chars.size());
    end
    tests_run++;
    if (got_reads.size() != 2 || got_reads[0] !== 32'h7FFF_FBF0 || got_reads[1] !== 32'h7FFF_FBF4) begin
      tests_failed++;
      $display("FAIL unal_reads: got %0d reads (first %h), expected 7ffffbf0 7ffffbf4",
               got_reads.size(), got_reads.size() > 0 ? got_reads[0] : 32'h0);
    end
  endtask

  task automatic test_starve();
    logic [31:0] b;
    bit to;
    int p0;
    b = 32'h3000_0000;
    mem[b] = 32'h5A59_5857;        // "WXYZ"
    mem[b + 4] = 32'h0000_7170;    // "pq\0\0"
    p0 = pass_err;
    run_string(b + 2, 100, 2, 1'b0, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL starve_timeout: no done pulse within budget"); end
    tests_run++;
    if (stall_cyc.size() != 2) begin
      tests_failed++;
      $display("FAIL starve_count: %0d stall cycles, expected 2", stall_cyc.size());
    end
    tests_run++;
    if (stall_cyc.size() < 1 || stall_cyc[0] - start_cyc != int'(STARVE_LIMIT) + 1) begin
      tests_failed++;
      $display("FAIL starve_first: stall offset %0d, expected %0d",
               stall_cyc.size() > 0 ? stall_cyc[0] - start_cyc : -1, STARVE_LIMIT + 1);
    end
    tests_run++;
    if (stall_cyc.size() < 2 || stall_cyc[1] - stall_cyc[0] != 1 + 2 + int'(STARVE_LIMIT) + 1) begin
      tests_failed++;
      $display("FAIL starve_second: stall gap %0d, expected %0d",
               stall_cyc.size() > 1 ? stall_cyc[1] - stall_cyc[0] : -1, STARVE_LIMIT + 4);
    end
    tests_run++;
    if (got_chars.size() != 4 || got_chars[0] !== 8'h59 || got_chars[3] !== 8'h71 ||
        got_reads.size() != 2 || got_reads[1] !== b + 4) begin
      tests_failed++;
      $display("FAIL starve_data: %0d chars %0d reads, expected 4 chars Y..q and 2 reads",
               got_chars.size(), got_reads.size());
    end
    tests_run++;
    if (pass_err != p0) begin
      tests_failed++;
      $display("FAIL starve_passthru: %0d cycles with CPU not passed through, expected 0", pass_err - p0);
    end
  endtask

  task automatic test_store_collision();
    logic [31:0] x, s;
    int d0;
    x = 32'h6000_0000;
    s = 32'h6000_0100;
    mem[x] = 32'h1111_1111;
    byte_wr(s, 8'h6F); byte_wr(s + 1, 8'h6B); byte_wr(s + 2, 8'h00);
    d0 = done_cnt;
    got_chars.delete();
    bus.start = 1'b1;
    bus.start_addr = s;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < int'(STARVE_LIMIT); i++) begin
      bus.cpu_memRead = 1'b1;
      bus.cpu_address = 32'h5000_0000;
      tick();
    end
    bus.cpu_memRead   = 1'b0;
    bus.cpu_memWrite  = 1'b1;
    bus.cpu_address   = x;
    bus.cpu_writeData = 32'hCAFE_F00D;
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.cpu_stall !== 1'b1 || bus.mem_memWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_denied: stall=%b mem_wr=%b, expected 1 and 0", bus.cpu_stall, bus.mem_memWrite);
    end
    tests_run++;
    if (mem_rd(x) !== 32'h1111_1111) begin
      tests_failed++;
      $display("FAIL store_blocked: mem=%h, expected 11111111", mem_rd(x));
    end
    tick();
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.cpu_stall !== 1'b0 || mem_rd(x) !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL store_retry: stall=%b mem=%h, expected 0 and cafef00d", bus.cpu_stall, mem_rd(x));
    end
    tick();
    cpu_idle();
    bus.char_ready = 1'b1;
    for (int i = 0; i < 50 && done_cnt == d0; i++) tick();
    bus.char_ready = 1'b0;
    tests_run++;
    if (done_cnt == d0 || got_chars.size() != 2 || got_chars[0] !== 8'h6F || got_chars[1] !== 8'h6B) begin
      tests_failed++;
      $display("FAIL store_string: done=%0d chars=%0d, expected done and o k", done_cnt - d0, got_chars.size());
    end
  endtask

  task automatic test_truncate();
    logic [31:0] b;
    bit to;
    int bad;
    b = 32'h7000_0001;
    for (int i = 0; i < 300; i++) byte_wr(b + 32'(i), 8'($urandom_range(1, 255)));
    byte_wr(b + 32'd300, 8'h00);
    model_string(b);
    run_string(b, 70, 1, 1'b0, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL trunc_timeout: no done pulse within budget"); end
    tests_run++;
    if (got_chars.size() != int'(MAX_LEN) || exp_chars.size() != int'(MAX_LEN)) begin
      tests_failed++;
      $display("FAIL trunc_len: %0d handshakes, expected %0d", got_chars.size(), MAX_LEN);
    end
    bad = -1;
    foreach (exp_chars[i]) if (bad < 0 && (i >= got_chars.size() || got_chars[i] !== exp_chars[i])) bad = i;
    tests_run++;
    if (bad >= 0) begin
      tests_failed++;
      $display("FAIL trunc_chars: first difference at index %0d, expected %h", bad, exp_chars[bad]);
    end
    tests_run++;
    if (last_trunc !== 1'b1 || got_reads.size() != exp_reads.size()) begin
      tests_failed++;
      $display("FAIL trunc_flag: trunc=%b reads=%0d, expected 1 and %0d", last_trunc,
               got_reads.size(), exp_reads.size());
    end
  endtask

  task automatic test_wrap();
    bit to;
    byte_wr(32'hFFFF_FFFE, 8'h41); byte_wr(32'hFFFF_FFFF, 8'h42);
    byte_wr(32'h0000_0000, 8'h43); byte_wr(32'h0000_0001, 8'h00);
    run_string(32'hFFFF_FFFE, 100, 0, 1'b0, to);
    tests_run++;
    if (to || got_chars.size() != 3 || got_chars[2] !== 8'h43 || got_reads.size() != 2 ||
        got_reads[0] !== 32'hFFFF_FFFC || got_reads[1] !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL wrap: timeout=%b chars=%0d reads=%0d, expected 0, 3 chars A B C, reads fffffffc 0",
               to, got_chars.size(), got_reads.size());
    end
  endtask

  task automatic test_random_strings();
    logic [31:0] a;
    bit to;
    int len, bad, p0;
    p0 = pass_err;
    for (int it = 0; it < 8; it++) begin
      a = 32'h2000_0000 + 32'(it) * 32'h400 + 32'($urandom_range(3));
      len = (it == 0) ? 0 : $urandom_range(24);
      for (int i = 0; i < len; i++) byte_wr(a + 32'(i), 8'($urandom_range(1, 255)));
      byte_wr(a + 32'(len), 8'h00);
      model_string(a);
      run_string(a, 60, 1, 1'b0, to);
      bad = -1;
      foreach (exp_chars[i]) if (bad < 0 && (i >= got_chars.size() || got_chars[i] !== exp_chars[i])) bad = i;
      tests_run++;
      if (to || bad >= 0 || got_chars.size() != exp_chars.size()) begin
        tests_failed++;
        $display("FAIL rand_chars[%0d]: timeout=%b got %0d chars, expected %0d (first diff %0d)",
                 it, to, got_chars.size(), exp_chars.size(), bad);
      end
      bad = -1;
      foreach (exp_reads[i]) if (bad < 0 && (i >= got_reads.size() || got_reads[i] !== exp_reads[i])) bad = i;
      tests_run++;
      if (bad >= 0 || got_reads.size() != exp_reads.size() || last_trunc !== exp_trunc) begin
        tests_failed++;
        $display("FAIL rand_reads[%0d]: got %0d reads trunc=%b, expected %0d reads trunc=%b",
                 it, got_reads.size(), last_trunc, exp_reads.size(), exp_trunc);
      end
    end
    tests_run++;
    if (pass_err != p0) begin
      tests_failed++;
      $display("FAIL rand_passthru: %0d cycles with CPU not passed through, expected 0", pass_err - p0);
    end
  endtask

  task automatic test_reset_midstring();
    logic [31:0] s;
    bit to;
    int d0;
    s = 32'h0800_0000;
    byte_wr(s, 8'h5A); byte_wr(s + 1, 8'h00);
    bus.start = 1'b1;
    bus.start_addr = s;
    bus.char_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    tests_run++;
    if (bus.char_valid !== 1'b1 || bus.char_data !== 8'h5A) begin
      tests_failed++;
      $display("FAIL rst_hold: valid=%b data=%h, expected 1 and 5a", bus.char_valid, bus.char_data);
    end
    d0 = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.char_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: valid=%b busy=%b, expected 0 0", bus.char_valid, bus.busy);
    end
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (done_cnt != d0) begin
      tests_failed++;
      $display("FAIL rst_nodone: %0d done pulses, expected 0", done_cnt - d0);
    end
    run_string(s, 100, 0, 1'b0, to);
    tests_run++;
    if (to || got_chars.size() != 1 || got_chars[0] !== 8'h5A || last_trunc !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_restart: timeout=%b chars=%0d, expected 0 and one 5a", to, got_chars.size());
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hi();
    test_unaligned();
    test_starve();
    test_store_collision();
    test_truncate();
    test_wrap();
    test_random_strings();
    test_reset_midstring();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
